// File: rtl/decode_issue_queue.sv
// Decode/issue queue: buffers fetched instructions in order, predicts the next
// PC at enqueue, and issues the head to RS/LSB with CDB operand forwarding.
module decode_issue_queue #(
   parameter int unsigned DEPTH          = 4,
   parameter int unsigned ROB_SIZE_WIDTH = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      rdy,
   input  logic                      flush,
   input  logic                      instr_valid,
   input  logic [31:0]               instr_in,
   input  logic [31:0]               instr_addr_in,
   output logic                      instr_accept,
   output logic                      predict_valid,
   output logic [31:0]               predict_pc,
   input  logic                      rob_full,
   input  logic                      rs_full,
   input  logic                      lsb_full,
   output logic [4:0]                reg_id1,
   output logic [4:0]                reg_id2,
   input  logic [31:0]               reg_value1_in,
   input  logic [31:0]               reg_value2_in,
   input  logic                      has_dep1_in,
   input  logic                      has_dep2_in,
   input  logic [ROB_SIZE_WIDTH-1:0] v_rob_id1_in,
   input  logic [ROB_SIZE_WIDTH-1:0] v_rob_id2_in,
   input  logic [ROB_SIZE_WIDTH-1:0] rd_rob_id_in,
   input  logic                      cdb_valid,
   input  logic [ROB_SIZE_WIDTH-1:0] cdb_rob_id,
   input  logic [31:0]               cdb_value,
   output logic                      issue_valid,
   output logic                      to_lsb,
   output logic [31:0]               instr_out,
   output logic [31:0]               instr_addr_out,
   output logic [2:0]                op_out,
   output logic [6:0]                instr_type_out,
   output logic [31:0]               imm,
   output logic [4:0]                rd,
   output logic [31:0]               reg_value1_out,
   output logic [31:0]               reg_value2_out,
   output logic                      has_dep1_out,
   output logic                      has_dep2_out,
   output logic [ROB_SIZE_WIDTH-1:0] v_rob_id1_out,
   output logic [ROB_SIZE_WIDTH-1:0] v_rob_id2_out,
   output logic [ROB_SIZE_WIDTH-1:0] rd_rob_id_out,
   output logic                      pred_taken_out
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_B     = 7'b1100011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_S     = 7'b0100011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_R     = 7'b0110011;

   // Sign-extended immediate for each instruction format
   function automatic logic [31:0] imm_of(input logic [31:0] ins);
      logic [31:0] r;
      case (ins[6:0])
         OP_LUI, OP_AUIPC:       r = {ins[31:12], 12'b0};
         OP_JAL:                 r = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
         OP_JALR, OP_LOAD, OP_I: r = {{20{ins[31]}}, ins[31:20]};
         OP_S:                   r = {{20{ins[31]}}, ins[31:25], ins[11:7]};
         OP_B:                   r = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
         default:                r = 32'h0;
      endcase
      return r;
   endfunction

   logic [31:0]      q_instr [DEPTH];
   logic [31:0]      q_pc    [DEPTH];
   logic             q_pred  [DEPTH];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [CNT_W-1:0] count;

   logic [31:0] head_instr;
   logic [6:0]  head_op;
   logic        head_is_ls;
   logic        use_rs1;
   logic        use_rs2;
   logic        has_rd;
   logic        do_enq;
   logic        do_issue;
   logic [31:0] enq_imm;
   logic        enq_taken;
   logic [31:0] enq_pred_pc;
   logic [31:0] op1_val;
   logic [31:0] op2_val;
   logic        op1_dep;
   logic        op2_dep;
   logic [ROB_SIZE_WIDTH-1:0] op1_tag;
   logic [ROB_SIZE_WIDTH-1:0] op2_tag;

   assign head_instr   = q_instr[head];
   assign head_op      = head_instr[6:0];
   assign head_is_ls   = (head_op == OP_LOAD) || (head_op == OP_S);
   assign use_rs1      = (head_op != OP_LUI) && (head_op != OP_AUIPC) && (head_op != OP_JAL);
   assign use_rs2      = (head_op == OP_R) || (head_op == OP_S) || (head_op == OP_B);
   assign has_rd       = (head_op != OP_B) && (head_op != OP_S);
   assign reg_id1      = head_instr[19:15];
   assign reg_id2      = head_instr[24:20];

   assign instr_accept = (count < CNT_W'(DEPTH)) && !flush && rdy;
   assign do_enq       = instr_valid && instr_accept;
   assign do_issue     = (count != '0) && !rob_full && !(head_is_ls ? lsb_full : rs_full);

   // Static next-PC prediction for the instruction being enqueued
   always_comb begin
      enq_imm     = imm_of(instr_in);
      enq_taken   = 1'b0;
      enq_pred_pc = instr_addr_in + 32'd4;
      if (instr_in[6:0] == OP_JAL) begin
         enq_taken   = 1'b1;
         enq_pred_pc = instr_addr_in + enq_imm;
      end else if (instr_in[6:0] == OP_B && enq_imm[31]) begin
         enq_taken   = 1'b1;
         enq_pred_pc = instr_addr_in + enq_imm;
      end
   end

   // Operand selection with same-cycle CDB forwarding, per operand
   always_comb begin
      op1_val = 32'h0;
      op1_dep = 1'b0;
      op1_tag = '0;
      op2_val = 32'h0;
      op2_dep = 1'b0;
      op2_tag = '0;
      if (use_rs1) begin
         op1_val = reg_value1_in;
         if (has_dep1_in) begin
            op1_tag = v_rob_id1_in;
            if (cdb_valid && cdb_rob_id == v_rob_id1_in) op1_val = cdb_value;
            else                                        op1_dep = 1'b1;
         end
      end
      if (use_rs2) begin
         op2_val = reg_value2_in;
         if (has_dep2_in) begin
            op2_tag = v_rob_id2_in;
            if (cdb_valid && cdb_rob_id == v_rob_id2_in) op2_val = cdb_value;
            else                                        op2_dep = 1'b1;
         end
      end
   end

   // Queue storage write on enqueue
   always_ff @(posedge clk) begin
      if (rst && do_enq) begin
         q_instr[tail] <= instr_in;
         q_pc[tail]    <= instr_addr_in;
         q_pred[tail]  <= enq_taken;
      end
   end

   // Pointers, prediction and registered issue outputs
   always_ff @(posedge clk) begin
      if (!rst) begin
         head           <= '0;
         tail           <= '0;
         count          <= '0;
         predict_valid  <= 1'b0;
         predict_pc     <= 32'h0;
         issue_valid    <= 1'b0;
         to_lsb         <= 1'b0;
         instr_out      <= 32'h0;
         instr_addr_out <= 32'h0;
         op_out         <= 3'h0;
         instr_type_out <= 7'h0;
         imm            <= 32'h0;
         rd             <= 5'h0;
         reg_value1_out <= 32'h0;
         reg_value2_out <= 32'h0;
         has_dep1_out   <= 1'b0;
         has_dep2_out   <= 1'b0;
         v_rob_id1_out  <= '0;
         v_rob_id2_out  <= '0;
         rd_rob_id_out  <= '0;
         pred_taken_out <= 1'b0;
      end else if (rdy) begin
         if (flush) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            predict_valid <= 1'b0;
            issue_valid   <= 1'b0;
         end else begin
            predict_valid <= do_enq;
            issue_valid   <= do_issue;
            if (do_enq) begin
               predict_pc <= enq_pred_pc;
               tail       <= tail + PTR_W'(1);
            end
            if (do_issue) begin
               head           <= head + PTR_W'(1);
               to_lsb         <= head_is_ls;
               instr_out      <= head_instr;
               instr_addr_out <= q_pc[head];
               op_out         <= head_instr[14:12];
               instr_type_out <= head_op;
               imm            <= imm_of(head_instr);
               rd             <= has_rd ? head_instr[11:7] : 5'h0;
               rd_rob_id_out  <= has_rd ? rd_rob_id_in : '0;
               reg_value1_out <= op1_val;
               reg_value2_out <= op2_val;
               has_dep1_out   <= op1_dep;
               has_dep2_out   <= op2_dep;
               v_rob_id1_out  <= op1_tag;
               v_rob_id2_out  <= op2_tag;
               pred_taken_out <= q_pred[head];
            end
            case ({do_enq, do_issue})
               2'b10:   count <= count + CNT_W'(1);
               2'b01:   count <= count - CNT_W'(1);
               default: count <= count;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_decode_issue_queue.sv
// Directed testbench for decode_issue_queue.
module tb_decode_issue_queue;

   localparam int unsigned RW = 4;

   logic          clk = 1'b0;
   logic          rst, rdy, flush, instr_valid;
   logic [31:0]   instr_in, instr_addr_in;
   logic          instr_accept, predict_valid;
   logic [31:0]   predict_pc;
   logic          rob_full, rs_full, lsb_full;
   logic [4:0]    reg_id1, reg_id2;
   logic [31:0]   reg_value1_in, reg_value2_in;
   logic          has_dep1_in, has_dep2_in;
   logic [RW-1:0] v_rob_id1_in, v_rob_id2_in, rd_rob_id_in;
   logic          cdb_valid;
   logic [RW-1:0] cdb_rob_id;
   logic [31:0]   cdb_value;
   logic          issue_valid, to_lsb;
   logic [31:0]   instr_out, instr_addr_out;
   logic [2:0]    op_out;
   logic [6:0]    instr_type_out;
   logic [31:0]   imm;
   logic [4:0]    rd;
   logic [31:0]   reg_value1_out, reg_value2_out;
   logic          has_dep1_out, has_dep2_out;
   logic [RW-1:0] v_rob_id1_out, v_rob_id2_out, rd_rob_id_out;
   logic          pred_taken_out;

   int tests = 0;
   int fails = 0;

   localparam logic [31:0] ADDI = 32'h00510093;
   localparam logic [31:0] BEQ  = 32'hFE000CE3;
   localparam logic [31:0] SW   = 32'h00112023;
   localparam logic [31:0] ADD  = 32'h002081B3;

   decode_issue_queue #(.DEPTH(4), .ROB_SIZE_WIDTH(RW)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
      .instr_valid(instr_valid), .instr_in(instr_in), .instr_addr_in(instr_addr_in),
      .instr_accept(instr_accept), .predict_valid(predict_valid), .predict_pc(predict_pc),
      .rob_full(rob_full), .rs_full(rs_full), .lsb_full(lsb_full),
      .reg_id1(reg_id1), .reg_id2(reg_id2),
      .reg_value1_in(reg_value1_in), .reg_value2_in(reg_value2_in),
      .has_dep1_in(has_dep1_in), .has_dep2_in(has_dep2_in),
      .v_rob_id1_in(v_rob_id1_in), .v_rob_id2_in(v_rob_id2_in), .rd_rob_id_in(rd_rob_id_in),
      .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_value(cdb_value),
      .issue_valid(issue_valid), .to_lsb(to_lsb),
      .instr_out(instr_out), .instr_addr_out(instr_addr_out),
      .op_out(op_out), .instr_type_out(instr_type_out), .imm(imm), .rd(rd),
      .reg_value1_out(reg_value1_out), .reg_value2_out(reg_value2_out),
      .has_dep1_out(has_dep1_out), .has_dep2_out(has_dep2_out),
      .v_rob_id1_out(v_rob_id1_out), .v_rob_id2_out(v_rob_id2_out),
      .rd_rob_id_out(rd_rob_id_out), .pred_taken_out(pred_taken_out)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0; rdy = 1'b1; flush = 1'b0; instr_valid = 1'b0;
      instr_in = 32'h0; instr_addr_in = 32'h0;
      rob_full = 1'b0; rs_full = 1'b0; lsb_full = 1'b0;
      reg_value1_in = 32'h0; reg_value2_in = 32'h0;
      has_dep1_in = 1'b0; has_dep2_in = 1'b0;
      v_rob_id1_in = '0; v_rob_id2_in = '0; rd_rob_id_in = '0;
      cdb_valid = 1'b0; cdb_rob_id = '0; cdb_value = 32'h0;
      step(); step();
      tests++;
      if ({issue_valid, predict_valid, to_lsb, pred_taken_out} !== 4'b0) begin
         fails++; $display("FAIL reset_flags got %b expected 0000", {issue_valid, predict_valid, to_lsb, pred_taken_out});
      end
      tests++;
      if ({predict_pc, instr_out, imm, reg_value1_out} !== 128'h0) begin
         fails++; $display("FAIL reset_data got pc=%h instr=%h imm=%h v1=%h expected 0", predict_pc, instr_out, imm, reg_value1_out);
      end
      tests++;
      if ({rd, rd_rob_id_out, op_out, instr_type_out} !== '0) begin
         fails++; $display("FAIL reset_fields got rd=%h rob=%h op=%h type=%h expected 0", rd, rd_rob_id_out, op_out, instr_type_out);
      end
      rst = 1'b1;
      #1;
      tests++;
      if (instr_accept !== 1'b1) begin
         fails++; $display("FAIL reset_accept got %b expected 1", instr_accept);
      end
   endtask

   task automatic test_addi();
      instr_valid = 1'b1; instr_in = ADDI; instr_addr_in = 32'h0;
      reg_value1_in = 32'd7; reg_value2_in = 32'hDEAD; rd_rob_id_in = 4'd5;
      step();
      instr_valid = 1'b0;
      tests++;
      if (predict_valid !== 1'b1 || predict_pc !== 32'h4) begin
         fails++; $display("FAIL addi_predict got v=%b pc=%h expected 1 00000004", predict_valid, predict_pc);
      end
      tests++;
      if (reg_id1 !== 5'd2 || issue_valid !== 1'b0) begin
         fails++; $display("FAIL addi_head got id1=%0d iv=%b expected 2 0", reg_id1, issue_valid);
      end
      step();
      tests++;
      if (issue_valid !== 1'b1 || imm !== 32'd5 || rd !== 5'd1 || to_lsb !== 1'b0) begin
         fails++; $display("FAIL addi_issue got iv=%b imm=%h rd=%0d lsb=%b expected 1 5 1 0", issue_valid, imm, rd, to_lsb);
      end
      tests++;
      if (reg_value1_out !== 32'd7 || reg_value2_out !== 32'h0 || has_dep2_out !== 1'b0 || rd_rob_id_out !== 4'd5) begin
         fails++; $display("FAIL addi_ops got v1=%h v2=%h d2=%b rob=%0d expected 7 0 0 5", reg_value1_out, reg_value2_out, has_dep2_out, rd_rob_id_out);
      end
      tests++;
      if (predict_valid !== 1'b0) begin
         fails++; $display("FAIL addi_predict_pulse got %b expected 0", predict_valid);
      end
      step();
      tests++;
      if (issue_valid !== 1'b0 || rd !== 5'd1) begin
         fails++; $display("FAIL addi_hold got iv=%b rd=%0d expected 0 1", issue_valid, rd);
      end
   endtask

   task automatic test_branch();
      instr_valid = 1'b1; instr_in = BEQ; instr_addr_in = 32'h100; rd_rob_id_in = 4'd5;
      step();
      instr_valid = 1'b0;
      tests++;
      if (predict_pc !== 32'hF8 || predict_valid !== 1'b1) begin
         fails++; $display("FAIL beq_predict got v=%b pc=%h expected 1 000000f8", predict_valid, predict_pc);
      end
      step();
      tests++;
      if (issue_valid !== 1'b1 || pred_taken_out !== 1'b1 || rd !== 5'd0 || rd_rob_id_out !== 4'd0) begin
         fails++; $display("FAIL beq_issue got iv=%b pt=%b rd=%0d rob=%0d expected 1 1 0 0", issue_valid, pred_taken_out, rd, rd_rob_id_out);
      end
      tests++;
      if (imm !== 32'hFFFFFFF8 || instr_type_out !== 7'h63 || instr_addr_out !== 32'h100) begin
         fails++; $display("FAIL beq_fields got imm=%h type=%h pc=%h expected fffffff8 63 100", imm, instr_type_out, instr_addr_out);
      end
   endtask

   task automatic test_lsb_block();
      lsb_full = 1'b1;
      instr_valid = 1'b1; instr_in = SW; instr_addr_in = 32'h200;
      step();
      instr_in = ADDI; instr_addr_in = 32'h204;
      step();
      instr_valid = 1'b0;
      step(); step();
      tests++;
      if (issue_valid !== 1'b0) begin
         fails++; $display("FAIL lsb_blocked got iv=%b expected 0", issue_valid);
      end
      lsb_full = 1'b0;
      step();
      tests++;
      if (issue_valid !== 1'b1 || to_lsb !== 1'b1 || instr_out !== SW || instr_addr_out !== 32'h200) begin
         fails++; $display("FAIL lsb_sw got iv=%b lsb=%b instr=%h pc=%h expected 1 1 %h 200", issue_valid, to_lsb, instr_out, instr_addr_out, SW);
      end
      step();
      tests++;
      if (issue_valid !== 1'b1 || to_lsb !== 1'b0 || instr_out !== ADDI || instr_addr_out !== 32'h204) begin
         fails++; $display("FAIL lsb_addi got iv=%b lsb=%b instr=%h pc=%h expected 1 0 %h 204", issue_valid, to_lsb, instr_out, instr_addr_out, ADDI);
      end
      step();
      tests++;
      if (issue_valid !== 1'b0) begin
         fails++; $display("FAIL lsb_drain got iv=%b expected 0", issue_valid);
      end
   endtask

   task automatic test_rob_full();
      rob_full = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         instr_valid = 1'b1;
         instr_in = 32'h00000093 | (32'(k) << 20);
         instr_addr_in = 32'(k) * 32'd4;
         #1;
         tests++;
         if (instr_accept !== (k <= 4)) begin
            fails++; $display("FAIL robfull_accept%0d got %b expected %b", k, instr_accept, (k <= 4));
         end
         step();
      end
      instr_valid = 1'b0;
      tests++;
      if (predict_valid !== 1'b0 || issue_valid !== 1'b0) begin
         fails++; $display("FAIL robfull_refused got pv=%b iv=%b expected 0 0", predict_valid, issue_valid);
      end
      rob_full = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         step();
         tests++;
         if (issue_valid !== 1'b1 || imm !== 32'(k)) begin
            fails++; $display("FAIL robfull_order%0d got iv=%b imm=%h expected 1 %h", k, issue_valid, imm, k);
         end
      end
      step();
      tests++;
      if (issue_valid !== 1'b0) begin
         fails++; $display("FAIL robfull_empty got iv=%b expected 0", issue_valid);
      end
   endtask

   task automatic test_cdb();
      instr_valid = 1'b1; instr_in = ADD; instr_addr_in = 32'h300;
      reg_value1_in = 32'h11; reg_value2_in = 32'h22; rd_rob_id_in = 4'd7;
      has_dep1_in = 1'b1; v_rob_id1_in = 4'd3;
      has_dep2_in = 1'b1; v_rob_id2_in = 4'd6;
      cdb_valid = 1'b1; cdb_rob_id = 4'd3; cdb_value = 32'h55;
      step();
      instr_valid = 1'b0;
      step();
      tests++;
      if (issue_valid !== 1'b1 || reg_value1_out !== 32'h55 || has_dep1_out !== 1'b0) begin
         fails++; $display("FAIL cdb_fwd got iv=%b v1=%h d1=%b expected 1 55 0", issue_valid, reg_value1_out, has_dep1_out);
      end
      tests++;
      if (has_dep2_out !== 1'b1 || v_rob_id2_out !== 4'd6 || rd !== 5'd3 || rd_rob_id_out !== 4'd7) begin
         fails++; $display("FAIL cdb_other got d2=%b t2=%0d rd=%0d rob=%0d expected 1 6 3 7", has_dep2_out, v_rob_id2_out, rd, rd_rob_id_out);
      end
      has_dep1_in = 1'b0; has_dep2_in = 1'b0; cdb_valid = 1'b0;
   endtask

   task automatic test_flush();
      rob_full = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         instr_valid = 1'b1;
         instr_in = 32'h00000093 | (32'(k) << 20);
         step();
      end
      rob_full = 1'b0; flush = 1'b1; instr_in = ADDI;
      #1;
      tests++;
      if (instr_accept !== 1'b0) begin
         fails++; $display("FAIL flush_accept got %b expected 0", instr_accept);
      end
      step();
      flush = 1'b0; instr_valid = 1'b0;
      tests++;
      if (issue_valid !== 1'b0 || predict_valid !== 1'b0) begin
         fails++; $display("FAIL flush_pulses got iv=%b pv=%b expected 0 0", issue_valid, predict_valid);
      end
      step(); step();
      tests++;
      if (issue_valid !== 1'b0) begin
         fails++; $display("FAIL flush_empty got iv=%b expected 0", issue_valid);
      end
      instr_valid = 1'b1; instr_in = 32'h00900093;
      step();
      instr_valid = 1'b0;
      step();
      tests++;
      if (issue_valid !== 1'b1 || imm !== 32'd9) begin
         fails++; $display("FAIL flush_after got iv=%b imm=%h expected 1 9", issue_valid, imm);
      end
   endtask

   task automatic test_rdy_hold();
      step();
      instr_valid = 1'b1; instr_in = 32'h00700093;
      step();
      instr_valid = 1'b0; rdy = 1'b0;
      step(); step();
      tests++;
      if (issue_valid !== 1'b0 || predict_valid !== 1'b1 || instr_accept !== 1'b0) begin
         fails++; $display("FAIL rdy_hold got iv=%b pv=%b acc=%b expected 0 1 0", issue_valid, predict_valid, instr_accept);
      end
      rdy = 1'b1;
      step();
      tests++;
      if (issue_valid !== 1'b1 || imm !== 32'd7 || predict_valid !== 1'b0) begin
         fails++; $display("FAIL rdy_resume got iv=%b imm=%h pv=%b expected 1 7 0", issue_valid, imm, predict_valid);
      end
   endtask

   initial begin
      test_reset();
      test_addi();
      test_branch();
      test_lsb_block();
      test_rob_full();
      test_cdb();
      test_flush();
      test_rdy_hold();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/decode_issue_queue.md
Name: decode_issue_queue

Overview:
- Parametrised successor to the single-slot decode/issue stage.
- Sits between the Fetcher and RS/LSB/RoB.
- Buffers fetched instructions in a DEPTH-entry in-order queue and predicts the next PC at enqueue. Supported prediction: JAL taken; conditional branches use static backward-taken/forward-not-taken.
- Issues the queue head when RoB and only the targeted unit (RS or LSB) have room.
- Forwards same-cycle CDB results into operands and supports a RoB-driven flush.

Parameters:
DEPTH, 4, queue entries; power of two, >=2.
ROB_SIZE_WIDTH, 4, RoB tag width.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; synchronous, active-low (0 = reset)
rdy  in  1  global enable; 0 freezes all state
flush  in  1  RoB mispredict clear
instr_valid  in  1  Fetcher offers instruction
instr_in  in  32  instruction word
instr_addr_in  in  32  instruction PC
instr_accept  out  1  comb: count<DEPTH && !flush && rdy
predict_valid  out  1  registered pulse, prediction ready
predict_pc  out  32  predicted next PC
rob_full, rs_full, lsb_full  in  1 each  structural full flags
reg_id1, reg_id2  out  5 each  comb: head rs1/rs2 to register file
reg_value1_in, reg_value2_in  in  32 each  register values
has_dep1_in, has_dep2_in  in  1 each  operand renamed
v_rob_id1_in, v_rob_id2_in  in  ROB_SIZE_WIDTH each  producer tags
rd_rob_id_in  in  ROB_SIZE_WIDTH  RoB tag to allocate
cdb_valid  in  1  result broadcast
cdb_rob_id  in  ROB_SIZE_WIDTH  broadcast tag
cdb_value  in  32  broadcast value
issue_valid  out  1  registered one-cycle issue pulse
to_lsb  out  1  issued instr is load/store
instr_out, instr_addr_out  out  32 each  issued word, PC
op_out  out  3  funct3
instr_type_out  out  7  opcode
imm  out  32  sign-extended immediate
rd  out  5  destination (0 if none)
reg_value1_out, reg_value2_out  out  32 each  operand values
has_dep1_out, has_dep2_out  out  1 each  operand still pending
v_rob_id1_out, v_rob_id2_out  out  ROB_SIZE_WIDTH each  pending tags
rd_rob_id_out  out  ROB_SIZE_WIDTH  allocated tag (0 if no rd)
pred_taken_out  out  1  prediction stored with entry

Behaviour:
- Priority: rst==0 > rdy==0 (hold everything) > flush > normal.
- Reset: head/tail/count=0; every output 0, including predict_pc.
- Enqueue when instr_valid && instr_accept. Store word, PC, pred_taken. Full with simultaneous dequeue still refuses; no bypass.
- Prediction is registered and produced on the enqueue cycle; predict_valid is high the next cycle only.
  - JAL: pc+imm, taken.
  - B_TYPE: pc+imm if imm[31], else pc+4.
  - JALR and all others: pc+4, not taken.
- Immediate formats: LUI/AUIPC U; JAL J; JALR, loads, I_TYPE I; S_TYPE S; B_TYPE B; R_TYPE 0.
- Issue condition: count>0 && !rob_full && !(head is load/store ? lsb_full : rs_full).
  - Strictly in order: a blocked head blocks younger entries.
- On issue, register all outputs from the head, pop the head, and pulse issue_valid.
  - issue_valid is 0 in any cycle without issue; other outputs hold.
- Latency: empty queue, accept at edge N; earliest issue_valid is the cycle after edge N+1.
- Operand use:
  - rs1 is used except by LUI/AUIPC/JAL.
  - rs2 is used by R, S, B.
  - Unused operand: value=0, dep=0, tag=0.
- CDB forwarding: for a used operand with has_dep_in=1 and cdb_valid && cdb_rob_id==v_rob_id_in, output value=cdb_value, dep=0. Each operand is checked independently.
- has_rd: not B_TYPE and not S_TYPE.
  - If has_rd: rd=instr[11:7], rd_rob_id_out=rd_rob_id_in.
  - Else: rd=0, rd_rob_id_out=0.
- Enqueue and dequeue in the same cycle leave count unchanged. Pointers wrap modulo DEPTH.
- Flush: pointers and count are cleared; issue_valid=0 and predict_valid=0 next cycle; that cycle's enqueue and issue are dropped; other outputs hold.

Test Plan:
- Reset: rst=0 two cycles -> all outputs 0, instr_accept=1 after release.
- ADDI x1,x2,5 (0x00510093) at PC 0x0, reg2=7, no deps:
  - predict_pc=0x4, predict_valid pulse.
  - Issue: imm=5, rd=1, reg_value1_out=7, has_dep2_out=0, to_lsb=0, rd_rob_id_out=rd_rob_id_in.
- BEQ x0,x0,-8 (0xFE000CE3) at 0x100 -> predict_pc=0xF8, pred_taken_out=1, rd=0, rd_rob_id_out=0.
- SW then ADDI, lsb_full=1 -> no issue_valid (ADDI blocked); lsb_full drops -> SW issues (to_lsb=1), ADDI next cycle.
- rob_full=1, DEPTH=4, stream 5 instrs -> 4 accepted, instr_accept=0 on 5th; clear rob_full -> issue order preserved.
- Head has_dep1_in=1, tag 3, cdb_valid with tag 3, value 0x55 -> reg_value1_out=0x55, has_dep1_out=0.
- Flush with 3 entries queued -> count=0, no issue_valid afterwards; new enqueue after flush issues normally.
